// File: rtl/oam_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : oam_bus_arbiter
// Purpose  : Sequencer/arbiter for the single 160-byte OAM port. Grants one
//            one-clock access at a time to the DMA engine, PPU sprite
//            scanner (two accesses: Y then X), PPU sprite fetcher and CPU,
//            with fixed priority dma > rend > scan > cpu. Drives registered
//            OAM address/strobes/write data, captures read data and returns
//            a one-cycle acknowledge to the winner.
// Ports    : clk1, nreset6 (async, active-low)
//            dma_run/dma_req/dma_idx/dma_d -> dma_ack
//            scan_req/scan_idx            -> scan_q{X,Y}, scan_ack
//            rend_req/rend_a              -> rend_q, rend_ack
//            cpu_req/cpu_wr/cpu_a/cpu_d   -> cpu_q, cpu_ack
//            oam_a/oam_do/oam_oe/oam_we, oam_di (RAM macro side)
//            grant {cpu,rend,scan,dma} one-hot, oam_bug
// Config   : define OAM_BUG_EN to build the OAM-corruption flag (oam_bug);
//            otherwise oam_bug is tied low.
// Revision : 1.0  initial release
// ============================================================================
module oam_bus_arbiter (
    input  logic        clk1,
    input  logic        nreset6,
    input  logic        dma_run,
    input  logic        dma_req,
    input  logic [7:0]  dma_idx,
    input  logic [7:0]  dma_d,
    output logic        dma_ack,
    input  logic        scan_req,
    input  logic [5:0]  scan_idx,
    output logic [15:0] scan_q,
    output logic        scan_ack,
    input  logic        rend_req,
    input  logic [7:0]  rend_a,
    output logic [7:0]  rend_q,
    output logic        rend_ack,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_a,
    input  logic [7:0]  cpu_d,
    output logic [7:0]  cpu_q,
    output logic        cpu_ack,
    output logic [7:0]  oam_a,
    output logic [7:0]  oam_do,
    input  logic [7:0]  oam_di,
    output logic        oam_oe,
    output logic        oam_we,
    output logic [3:0]  grant,
    output logic        oam_bug
);

    localparam logic [7:0] OAM_SIZE    = 8'd160;
    localparam logic [5:0] LAST_SPRITE = 6'd39;
    localparam logic [7:0] DMA_LOCK_Q  = 8'hFF;
    localparam logic [7:0] OOB_Q       = 8'h00;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DMA    = 3'd1,
        S_SCAN_Y = 3'd2,
        S_SCAN_X = 3'd3,
        S_REND   = 3'd4,
        S_CPU    = 3'd5
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [3:0]  owner;       // requester finishing this cycle
    logic [3:0]  req_vec;     // requests eligible for the next grant
    logic [3:0]  grant_next;

    logic [5:0]  scan_idx_lat;
    logic        scan_valid;
    logic [7:0]  scan_y;
    logic        cpu_wr_lat;
    logic        cpu_blocked;
    logic        cpu_oob;

    // Arbitration. The requester whose access ends at this edge is masked:
    // it still holds its level request until it sees the ack, so only a
    // request still high at the ack edge counts as a new one.
    always_comb begin
        owner = 4'b0000;
        case (state)
            S_DMA:    owner = 4'b0001;
            S_SCAN_X: owner = 4'b0010;
            S_REND:   owner = 4'b0100;
            S_CPU:    owner = 4'b1000;
            default:  owner = 4'b0000;
        endcase

        req_vec = {cpu_req, rend_req, scan_req, dma_req} & ~owner;

        next_state = S_IDLE;
        if (state == S_SCAN_Y)
            next_state = S_SCAN_X;      // scan is an indivisible pair
        else if (req_vec[0])
            next_state = S_DMA;
        else if (req_vec[2])
            next_state = S_REND;
        else if (req_vec[1])
            next_state = S_SCAN_Y;
        else if (req_vec[3])
            next_state = S_CPU;

        grant_next = 4'b0000;
        case (next_state)
            S_DMA:    grant_next = 4'b0001;
            S_SCAN_Y,
            S_SCAN_X: grant_next = 4'b0010;
            S_REND:   grant_next = 4'b0100;
            S_CPU:    grant_next = 4'b1000;
            default:  grant_next = 4'b0000;
        endcase
    end

    always_ff @(posedge clk1 or negedge nreset6) begin
        if (!nreset6) begin
            state        <= S_IDLE;
            grant        <= 4'b0000;
            oam_a        <= 8'h00;
            oam_do       <= 8'h00;
            oam_oe       <= 1'b0;
            oam_we       <= 1'b0;
            dma_ack      <= 1'b0;
            scan_q       <= 16'h0000;
            scan_ack     <= 1'b0;
            rend_q       <= 8'h00;
            rend_ack     <= 1'b0;
            cpu_q        <= 8'h00;
            cpu_ack      <= 1'b0;
            scan_idx_lat <= 6'd0;
            scan_valid   <= 1'b0;
            scan_y       <= 8'h00;
            cpu_wr_lat   <= 1'b0;
            cpu_blocked  <= 1'b0;
            cpu_oob      <= 1'b0;
        end else begin
            state    <= next_state;
            grant    <= grant_next;
            oam_oe   <= 1'b0;
            oam_we   <= 1'b0;
            dma_ack  <= 1'b0;
            scan_ack <= 1'b0;
            rend_ack <= 1'b0;
            cpu_ack  <= 1'b0;

            // Completion of the access that occupied the bus this cycle.
            case (state)
                S_DMA: dma_ack <= 1'b1;
                S_SCAN_Y: scan_y <= scan_valid ? oam_di : 8'h00;
                S_SCAN_X: begin
                    scan_q   <= scan_valid ? {oam_di, scan_y} : 16'h0000;
                    scan_ack <= 1'b1;
                end
                S_REND: begin
                    rend_q   <= oam_di;
                    rend_ack <= 1'b1;
                end
                S_CPU: begin
                    if (!cpu_wr_lat) begin
                        if (cpu_blocked)
                            cpu_q <= DMA_LOCK_Q;
                        else if (cpu_oob)
                            cpu_q <= OOB_Q;
                        else
                            cpu_q <= oam_di;
                    end
                    cpu_ack <= 1'b1;
                end
                default: ;
            endcase

            // Set-up of the access granted for the next cycle.
            case (next_state)
                S_DMA: begin
                    oam_a  <= dma_idx;
                    oam_do <= dma_d;
                    oam_we <= (dma_idx < OAM_SIZE);
                end
                S_SCAN_Y: begin
                    scan_idx_lat <= scan_idx;
                    scan_valid   <= (scan_idx <= LAST_SPRITE);
                    if (scan_idx <= LAST_SPRITE) begin
                        oam_a  <= {scan_idx, 2'b00};
                        oam_oe <= 1'b1;
                    end
                end
                S_SCAN_X: begin
                    if (scan_valid) begin
                        oam_a  <= {scan_idx_lat, 2'b01};
                        oam_oe <= 1'b1;
                    end
                end
                S_REND: begin
                    oam_a  <= rend_a;
                    oam_oe <= 1'b1;
                end
                S_CPU: begin
                    // Lockout/range decisions are frozen at grant so a
                    // dma_run edge mid-access cannot alter it.
                    cpu_wr_lat  <= cpu_wr;
                    cpu_blocked <= dma_run;
                    cpu_oob     <= (cpu_a >= OAM_SIZE);
                    if (!dma_run && (cpu_a < OAM_SIZE)) begin
                        oam_a <= cpu_a;
                        if (cpu_wr) begin
                            oam_do <= cpu_d;
                            oam_we <= 1'b1;
                        end else begin
                            oam_oe <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef OAM_BUG_EN
    // A CPU grant while the scanner is active, or right after its last
    // read, is the DMG OAM-corruption window.
    always_ff @(posedge clk1 or negedge nreset6) begin
        if (!nreset6)
            oam_bug <= 1'b0;
        else
            oam_bug <= (next_state == S_CPU) && (scan_req || (state == S_SCAN_X));
    end
`else
    assign oam_bug = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_oam_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_oam_bus_arbiter
// Purpose  : Self-checking bench for oam_bus_arbiter with a behavioural
//            160-byte OAM RAM, a vector table and hand-written sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_oam_bus_arbiter;

    logic        clk1 = 1'b0;
    logic        nreset6;
    logic        dma_run, dma_req, scan_req, rend_req, cpu_req, cpu_wr;
    logic [7:0]  dma_idx, dma_d, rend_a, cpu_a, cpu_d;
    logic [5:0]  scan_idx;
    logic        dma_ack, scan_ack, rend_ack, cpu_ack, oam_oe, oam_we, oam_bug;
    logic [15:0] scan_q;
    logic [7:0]  rend_q, cpu_q, oam_a, oam_do, oam_di;
    logic [3:0]  grant;

`ifdef OAM_BUG_EN
    localparam logic BUG_EXP = 1'b1;
`else
    localparam logic BUG_EXP = 1'b0;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk1 = ~clk1;

    oam_bus_arbiter dut (
        .clk1(clk1), .nreset6(nreset6), .dma_run(dma_run),
        .dma_req(dma_req), .dma_idx(dma_idx), .dma_d(dma_d), .dma_ack(dma_ack),
        .scan_req(scan_req), .scan_idx(scan_idx), .scan_q(scan_q), .scan_ack(scan_ack),
        .rend_req(rend_req), .rend_a(rend_a), .rend_q(rend_q), .rend_ack(rend_ack),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_a(cpu_a), .cpu_d(cpu_d),
        .cpu_q(cpu_q), .cpu_ack(cpu_ack),
        .oam_a(oam_a), .oam_do(oam_do), .oam_di(oam_di),
        .oam_oe(oam_oe), .oam_we(oam_we), .grant(grant), .oam_bug(oam_bug)
    );

    // Behavioural OAM RAM: asynchronous read, write on rising edge.
    logic [7:0] mem [0:159];
    logic       preload;
    always @(posedge clk1) begin
        if (preload) begin
            for (int i = 0; i < 160; i++) mem[i] <= 8'(i) ^ 8'hA0;
            mem[8] <= 8'h20;
            mem[9] <= 8'h18;
        end else if (oam_we && oam_a < 8'd160) begin
            mem[oam_a] <= oam_do;
        end
    end
    assign oam_di = (oam_a < 8'd160) ? mem[oam_a] : 8'h00;

    wire [63:0] all_out = {5'b0, dma_ack, scan_q, scan_ack, rend_q, rend_ack, cpu_q,
                           cpu_ack, oam_a, oam_do, oam_oe, oam_we, grant, oam_bug};
    wire [3:0]  acks    = {cpu_ack, rend_ack, scan_ack, dma_ack};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // kind: 0 dma, 1 scan, 2 rend, 3 cpu
    typedef struct {
        logic [1:0]  kind;
        logic        wr;
        logic        run;
        logic [7:0]  addr;
        logic [7:0]  data;
        logic        chk_a;
        logic [7:0]  exp_a;
        logic        exp_oe;
        logic        exp_we;
        logic        has_q;
        logic [15:0] exp_q;
    } vec_t;

    typedef struct {
        logic [1:0]  kind;
        logic        has_q;
        logic [15:0] q;
        int          lat;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[16];

    function automatic vec_t mk(logic [1:0] kind, logic wr, logic run, logic [7:0] addr,
                                logic [7:0] data, logic chk_a, logic [7:0] exp_a,
                                logic exp_oe, logic exp_we, logic has_q, logic [15:0] exp_q);
        vec_t v;
        v.kind = kind; v.wr = wr; v.run = run; v.addr = addr; v.data = data;
        v.chk_a = chk_a; v.exp_a = exp_a; v.exp_oe = exp_oe; v.exp_we = exp_we;
        v.has_q = has_q; v.exp_q = exp_q;
        return v;
    endfunction

    task automatic clear_reqs();
        dma_req = 0; scan_req = 0; rend_req = 0; cpu_req = 0; cpu_wr = 0; dma_run = 0;
    endtask

    task automatic score(input int id, input int cyc);
        sb_t e;
        logic [15:0] q;
        if (sb_q.size() == 0) begin
            chk($sformatf("v%0d unexpected ack", id), 64'(acks), 64'h0);
            return;
        end
        e = sb_q.pop_front();
        chk($sformatf("v%0d ack sel", id), 64'(acks), 64'(4'b0001 << e.kind));
        chk($sformatf("v%0d latency", id), 64'(cyc), 64'(e.lat));
        if (e.has_q) begin
            q = (e.kind == 2'd1) ? scan_q : (e.kind == 2'd2) ? {8'h00, rend_q} : {8'h00, cpu_q};
            chk($sformatf("v%0d data", id), 64'(q), 64'(e.q));
        end
    endtask

    task automatic do_vec(input vec_t v, input int id);
        sb_t  e;
        int   cyc;
        logic seen;
        @(negedge clk1);
        dma_run = v.run;
        case (v.kind)
            2'd0: begin dma_req = 1; dma_idx = v.addr; dma_d = v.data; end
            2'd1: begin scan_req = 1; scan_idx = v.addr[5:0]; end
            2'd2: begin rend_req = 1; rend_a = v.addr; end
            default: begin cpu_req = 1; cpu_wr = v.wr; cpu_a = v.addr; cpu_d = v.data; end
        endcase
        e.kind = v.kind; e.has_q = v.has_q; e.q = v.exp_q;
        e.lat  = (v.kind == 2'd1) ? 3 : 2;
        sb_q.push_back(e);
        cyc = 0; seen = 0;
        while (!seen && cyc < 8) begin
            @(posedge clk1); cyc++;
            @(negedge clk1);
            if (cyc == 1) begin
                chk($sformatf("v%0d grant", id), 64'(grant), 64'(4'b0001 << v.kind));
                chk($sformatf("v%0d oe", id), 64'(oam_oe), 64'(v.exp_oe));
                chk($sformatf("v%0d we", id), 64'(oam_we), 64'(v.exp_we));
                if (v.chk_a) chk($sformatf("v%0d addr", id), 64'(oam_a), 64'(v.exp_a));
                if (v.exp_we) chk($sformatf("v%0d wdata", id), 64'(oam_do), 64'(v.data));
            end
            if (cyc == 2 && v.kind == 2'd1) begin
                chk($sformatf("v%0d scan x oe", id), 64'(oam_oe), 64'(v.exp_oe));
                if (v.exp_oe) chk($sformatf("v%0d scan x addr", id), 64'(oam_a), 64'(v.exp_a + 8'd1));
            end
            if (acks != 4'b0000) begin
                seen = 1;
                score(id, cyc);
            end
        end
        if (!seen) begin
            n_cmp++; n_fail++;
            $display("FAIL v%0d timeout: no ack after %0d cycles, want ack", id, cyc);
            void'(sb_q.pop_front());
        end
        clear_reqs();
        @(posedge clk1); @(negedge clk1);
        chk($sformatf("v%0d idle after", id), 64'({grant, acks}), 64'h0);
    endtask

    initial begin
        int   seen;
        nreset6 = 0; preload = 1;
        clear_reqs();
        dma_idx = 0; dma_d = 0; scan_idx = 0; rend_a = 0; cpu_a = 0; cpu_d = 0;

        //            kind wr run addr   data   chk_a exp_a  oe we has_q exp_q
        vecs[0]  = mk(2'd3, 1, 0, 8'h10, 8'h5A, 1, 8'h10, 0, 1, 0, 16'h0000);
        vecs[1]  = mk(2'd3, 0, 0, 8'h10, 8'h00, 1, 8'h10, 1, 0, 1, 16'h005A);
        vecs[2]  = mk(2'd0, 0, 0, 8'h03, 8'hC3, 1, 8'h03, 0, 1, 0, 16'h0000);
        vecs[3]  = mk(2'd2, 0, 0, 8'h03, 8'h00, 1, 8'h03, 1, 0, 1, 16'h00C3);
        vecs[4]  = mk(2'd1, 0, 0, 8'h02, 8'h00, 1, 8'h08, 1, 0, 1, 16'h1820);
        vecs[5]  = mk(2'd3, 0, 1, 8'h00, 8'h00, 0, 8'h00, 0, 0, 1, 16'h00FF);
        vecs[6]  = mk(2'd3, 0, 0, 8'hA5, 8'h00, 0, 8'h00, 0, 0, 1, 16'h0000);
        vecs[7]  = mk(2'd0, 0, 0, 8'hA0, 8'h99, 1, 8'hA0, 0, 0, 0, 16'h0000);
        vecs[8]  = mk(2'd3, 1, 1, 8'h20, 8'h44, 0, 8'h00, 0, 0, 0, 16'h0000);
        vecs[9]  = mk(2'd3, 0, 0, 8'h20, 8'h00, 1, 8'h20, 1, 0, 1, 16'h0080);
        vecs[10] = mk(2'd1, 0, 0, 8'h28, 8'h00, 0, 8'h00, 0, 0, 1, 16'h0000);
        vecs[11] = mk(2'd1, 0, 0, 8'h27, 8'h00, 1, 8'h9C, 1, 0, 1, 16'h3D3C);
        vecs[12] = mk(2'd2, 0, 0, 8'h9F, 8'h00, 1, 8'h9F, 1, 0, 1, 16'h003F);
        vecs[13] = mk(2'd0, 0, 0, 8'h9F, 8'hE1, 1, 8'h9F, 0, 1, 0, 16'h0000);
        vecs[14] = mk(2'd3, 0, 0, 8'h9F, 8'h00, 1, 8'h9F, 1, 0, 1, 16'h00E1);
        vecs[15] = mk(2'd3, 1, 0, 8'hA5, 8'h77, 0, 8'h00, 0, 0, 0, 16'h0000);

        repeat (2) @(posedge clk1);
        @(negedge clk1);
        preload = 0;
        chk("reset outputs", all_out, 64'h0);
        nreset6 = 1;

        for (int i = 0; i < 16; i++) do_vec(vecs[i], i);

        // DMA and CPU raised together: DMA first, CPU chained at DMA's last cycle.
        @(negedge clk1);
        dma_req = 1; dma_idx = 8'h03; dma_d = 8'hC3;
        cpu_req = 1; cpu_wr = 0; cpu_a = 8'h03;
        @(posedge clk1); @(negedge clk1);
        chk("dc grant dma", 64'(grant), 64'(4'b0001));
        chk("dc no cpu ack", 64'(cpu_ack), 64'h0);
        @(posedge clk1); @(negedge clk1);
        chk("dc dma ack", 64'(acks), 64'(4'b0001));
        chk("dc grant cpu", 64'(grant), 64'(4'b1000));
        dma_req = 0;
        @(posedge clk1); @(negedge clk1);
        chk("dc cpu ack", 64'(acks), 64'(4'b1000));
        chk("dc cpu q", 64'(cpu_q), 64'h00C3);
        clear_reqs();

        // rend beats scan; scan follows back-to-back.
        @(negedge clk1);
        rend_req = 1; rend_a = 8'h09; scan_req = 1; scan_idx = 6'd2;
        @(posedge clk1); @(negedge clk1);
        chk("rs grant rend", 64'(grant), 64'(4'b0100));
        @(posedge clk1); @(negedge clk1);
        chk("rs rend ack", 64'({acks, rend_q}), 64'({4'b0100, 8'h18}));
        chk("rs grant scan", 64'(grant), 64'(4'b0010));
        rend_req = 0;
        @(posedge clk1); @(negedge clk1);
        @(posedge clk1); @(negedge clk1);
        chk("rs scan ack", 64'({acks, scan_q}), 64'({4'b0010, 16'h1820}));
        clear_reqs();

        // CPU granted right after SCAN_X: corruption flag window.
        @(negedge clk1);
        scan_req = 1; scan_idx = 6'd2; cpu_req = 1; cpu_wr = 0; cpu_a = 8'h08;
        @(posedge clk1); @(negedge clk1);
        chk("bug grant scan", 64'({grant, oam_bug}), 64'({4'b0010, 1'b0}));
        @(posedge clk1); @(negedge clk1);
        @(posedge clk1); @(negedge clk1);
        chk("bug scan ack", 64'(acks), 64'(4'b0010));
        chk("bug flag", 64'({grant, oam_bug}), 64'({4'b1000, BUG_EXP}));
        scan_req = 0;
        @(posedge clk1); @(negedge clk1);
        chk("bug cpu ack", 64'({acks, cpu_q, oam_bug}), 64'({4'b1000, 8'h20, 1'b0}));
        clear_reqs();

        // Reset pulsed during SCAN_X.
        @(negedge clk1);
        scan_req = 1; scan_idx = 6'd2;
        @(posedge clk1); @(negedge clk1);
        @(posedge clk1); @(negedge clk1);
        chk("rst in scan_x", 64'({oam_oe, oam_a}), 64'({1'b1, 8'h09}));
        nreset6 = 0;
        #1;
        chk("rst async clear", all_out, 64'h0);
        scan_req = 0;
        @(posedge clk1); @(negedge clk1);
        nreset6 = 1;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk1); @(negedge clk1);
            if (scan_ack) seen = 1;
        end
        chk("rst ack lost", 64'(seen), 64'h0);
        do_vec(vecs[4], 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/oam_bus_arbiter.md
# oam_bus_arbiter

Sequencer and arbiter for the 160-byte OAM bus. It shares the single OAM address/data port between four requesters: the OAM DMA engine, the PPU sprite scanner, the PPU sprite fetcher and the CPU. It grants one one-clock access at a time, drives the OAM address, enable and data lines, captures read data and returns a one-cycle acknowledge to the winner. It sits between the DMA page, the PPU sprite logic and the OAM RAM macro.

## Interface
Parameters: none.

Ports:
- clk1  in  1  system clock; all state updates on rising edge.
- nreset6  in  1  reset, asynchronous, active-low.
- dma_run  in  1  OAM DMA in progress; locks the CPU out of OAM.
- dma_req  in  1  DMA write request, level, held until dma_ack.
- dma_idx  in  8  OAM byte offset for the DMA write.
- dma_d  in  8  DMA source byte.
- dma_ack  out  1  one-cycle pulse: DMA byte written.
- scan_req  in  1  scanner request, level.
- scan_idx  in  6  sprite number 0..39; reads bytes 4*idx (Y) and 4*idx+1 (X).
- scan_q  out  16  {X,Y} result.
- scan_ack  out  1  one-cycle pulse.
- rend_req  in  1  fetcher request, level.
- rend_a  in  8  OAM byte address.
- rend_q  out  8  read data.
- rend_ack  out  1  one-cycle pulse.
- cpu_req, cpu_wr  in  1  CPU access request (level) and write qualifier.
- cpu_a, cpu_d  in  8  CPU offset (FE00 base removed) and write data.
- cpu_q  out  8  CPU read data.
- cpu_ack  out  1  one-cycle pulse.
- oam_a  out  8  OAM address.
- oam_do  out  8  OAM write data.
- oam_di  in  8  OAM read data.
- oam_oe, oam_we  out  1  OAM read / write strobes.
- grant  out  4  one-hot owner {cpu,rend,scan,dma}; 0 when idle.
- oam_bug  out  1  see Configuration.

## Operation
- States: IDLE, DMA, SCAN_Y, SCAN_X, REND, CPU.
- Arbitration happens in IDLE and on the last cycle of every access, which allows back-to-back grants.
- Fixed priority: dma_req > rend_req > scan_req > cpu_req. There is no fairness; a continuously asserted higher request starves lower ones.
- DMA: oam_a=dma_idx, oam_do=dma_d, oam_we=1 for one cycle. If dma_idx ≥ 160, oam_we stays 0 but dma_ack still pulses.
- SCAN_Y then SCAN_X: oam_oe=1, oam_a=4*scan_idx then 4*scan_idx+1. Y is captured at the end of SCAN_Y, X at the end of SCAN_X. scan_q updates and scan_ack pulses after SCAN_X. The 8-bit address arithmetic cannot overflow for idx ≤ 39. For idx > 39, scan_q = 16'h0000 and no OAM cycle occurs, but the 2-cycle timing is kept.
- REND: oam_oe=1, oam_a=rend_a, and rend_q captures oam_di.
- CPU while dma_run=1: granted immediately without touching OAM. Reads return cpu_q=8'hFF, writes are dropped, and cpu_ack pulses.
- CPU with cpu_a ≥ 160: reads return 8'h00, writes are dropped, and cpu_ack pulses.
- Otherwise the CPU performs a normal read or write cycle.
- oam_a, oam_oe, oam_we, oam_do and grant are registered. Outside a granted access oam_oe=oam_we=0 and oam_a/oam_do hold their last value.
- Reset values: every output 0 and the state is IDLE.

## Timing
- A request sampled at edge N in IDLE is granted, and its bus cycle runs from N to N+1.
- Read data is captured at edge N+1.
- *_q and *_ack are valid in the cycle N+1..N+2.
- Latency from request to ack: 2 clocks for DMA/REND/CPU, 3 clocks for SCAN.
- A requester must deassert or change its request in the ack cycle. A request still high at the ack edge is treated as a new request.
- Simultaneous requests: the winner's grant is asserted; losers see no ack and keep waiting.
- dma_run rising during a CPU access already granted: that access completes normally.
- Reset asserted mid-access: outputs clear asynchronously, the state returns to IDLE, and the pending ack is lost. Requesters re-request after release.

## Configuration
- OAM_BUG_EN defined: a CPU access granted while scan_req=1, or during the cycle immediately after a SCAN_X, pulses oam_bug for one cycle. This flags the DMG OAM-corruption condition for the PPU model. The access itself proceeds unchanged.
- Not defined: oam_bug is tied to 0 and no detection logic is built.

## Test plan
- Reset, then cpu_req=1, cpu_wr=1, cpu_a=8'h10, cpu_d=8'h5A -> oam_we=1, oam_a=8'h10, oam_do=8'h5A one clock after sampling; cpu_ack one clock later. A following read of 8'h10 returns cpu_q=8'h5A.
- dma_req and cpu_req raised in the same cycle with dma_idx=8'h03, dma_d=8'hC3 -> grant=4'b0001 first. After dma_ack, the CPU is granted on the next arbitration (grant=4'b1000).
- OAM preloaded with bytes 8 and 9 = 8'h20, 8'h18; scan_req with scan_idx=2 -> oam_a=8'h08 then 8'h09; scan_q=16'h1820, and scan_ack arrives 3 clocks after the request.
- dma_run=1 with a CPU read of 8'h00 -> cpu_q=8'hFF, cpu_ack with oam_oe never asserted. A CPU read of 8'hA5 with dma_run=0 -> cpu_q=8'h00.
- nreset6 pulsed low during SCAN_X -> all outputs 0 immediately, no scan_ack. After release, re-raising scan_req completes normally.
- With OAM_BUG_EN: CPU read while scan_req=1 -> oam_bug one-cycle pulse. Without OAM_BUG_EN, the same stimulus keeps oam_bug=0.
